// File: rtl/alu_pipe.sv
// alu_pipe -- pipelined execute-stage ALU with valid/ready on both sides.
//
// Computes one of AND/OR/ADD/SUB/XOR/SLL/SRL/SRA/SLT/SLTU on rdata1_i and
// operand2 (rdata2_i or imme_i, selected by alusrc_i). In parallel it evaluates
// a branch compare on the same two operands. {result, branch} pass through two
// registered stages (S1, then the S2 output register), giving a latency of two
// cycles and a throughput of one op per cycle. Backpressure from out_ready_i
// stalls both stages without losing, duplicating or reordering ops.
//
// Optional feature, macro ALU_PIPE_MUL_EN: opcode 1010 becomes an unsigned
// shift-add multiply (low WIDTH bits of the product), one bit per cycle for
// WIDTH cycles. Without the macro, 1010 is a single-cycle op yielding 0, and
// the FSM stays in IDLE.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid_i      op presented          in_ready_o     op accepted this cycle
//   alu_ctrl_i      opcode                compare_i      branch compare select
//   alusrc_i        1: operand2=rdata2_i, 0: operand2=imme_i
//   rdata1_i, rdata2_i, imme_i            operands
//   out_valid_o     result valid          out_ready_i    consumer accepts result
//   result_o        ALU result            result_high_o  top HIGH_W bits of result_o
//   branch_o        compare outcome
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, while in_ready_o may combinationally
// depend on out_ready_i.
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int HIGH_W  = 22,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        alu_ctrl_i,
  input  logic [2:0]        compare_i,
  input  logic              alusrc_i,
  input  logic [WIDTH-1:0]  rdata1_i,
  input  logic [WIDTH-1:0]  rdata2_i,
  input  logic [WIDTH-1:0]  imme_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  result_o,
  output logic [HIGH_W-1:0] result_high_o,
  output logic              branch_o
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_WAIT} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   op2;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_br;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_result;
  logic               s1_branch;

  logic               s2_load;
  logic               s1_free;
  logic               accept;
  logic               mul_accept;
  logic               mul_store;
  logic [WIDTH-1:0]   mul_result;

  assign op2   = alusrc_i ? rdata2_i : imme_i;
  assign shamt = op2[SHAMT_W-1:0];

  // S2 refills whenever it is empty or being drained; S1 moves into S2 on the
  // same condition, so S1 is free when empty or advancing.
  assign s2_load = !out_valid_o || out_ready_i;
  assign s1_free = !s1_valid || s2_load;
  assign accept  = in_valid_i && in_ready_o;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_i)
      4'b0000: alu_res = rdata1_i & op2;
      4'b0001: alu_res = rdata1_i | op2;
      4'b0010: alu_res = rdata1_i + op2;
      4'b0110: alu_res = rdata1_i - op2;
      4'b0011: alu_res = rdata1_i ^ op2;
      4'b0100: alu_res = rdata1_i << shamt;
      4'b0101: alu_res = rdata1_i >> shamt;
      4'b0111: alu_res = WIDTH'($signed(rdata1_i) >>> shamt);
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, $signed(rdata1_i) < $signed(op2)};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, rdata1_i < op2};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_br = 1'b0;
    case (compare_i)
      3'b000:  alu_br = (rdata1_i == op2);
      3'b001:  alu_br = (rdata1_i != op2);
      3'b100:  alu_br = ($signed(rdata1_i) <  $signed(op2));
      3'b101:  alu_br = ($signed(rdata1_i) >= $signed(op2));
      3'b110:  alu_br = (rdata1_i <  op2);
      3'b111:  alu_br = (rdata1_i >= op2);
      default: alu_br = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0]   mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [WIDTH-1:0]   mul_acc;
  logic [SHAMT_W-1:0] mul_cnt;

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (mul_accept) next_state = MUL_RUN;
      MUL_RUN:  if (mul_cnt == SHAMT_W'(WIDTH-1)) next_state = MUL_WAIT;
      MUL_WAIT: if (s1_free) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o = s1_free && (state == IDLE);
    mul_accept = in_valid_i && in_ready_o && (alu_ctrl_i == 4'b1010);
    mul_store  = (state == MUL_WAIT) && s1_free;
  end

  // Shift-add: one multiplier bit per cycle, the multiplicand shifts left.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
    end else if (mul_accept) begin
      mul_mcand  <= rdata1_i;
      mul_mplier <= op2;
      mul_acc    <= '0;
      mul_cnt    <= '0;
    end else if (state == MUL_RUN) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
    end
  end

  assign mul_result = mul_acc;
`else
  // FSM: next-state logic (no multiplier, always IDLE)
  always_comb begin
    next_state = IDLE;
  end

  // FSM: outputs
  always_comb begin
    in_ready_o = s1_free && (state == IDLE);
    mul_accept = 1'b0;
    mul_store  = 1'b0;
  end

  assign mul_result = '0;
`endif

  // S1: loaded by an accepted single-cycle op or by a finished multiply,
  // emptied when it advances into S2 with nothing replacing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_branch <= 1'b0;
    end else if (accept && !mul_accept) begin
      s1_valid  <= 1'b1;
      s1_result <= alu_res;
      s1_branch <= alu_br;
    end else if (mul_store) begin
      s1_valid  <= 1'b1;
      s1_result <= mul_result;
      s1_branch <= 1'b0;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      branch_o    <= 1'b0;
    end else if (s2_load) begin
      out_valid_o <= s1_valid;
      result_o    <= s1_result;
      branch_o    <= s1_branch;
    end
  end

  assign result_high_o = result_o[WIDTH-1 -: HIGH_W];

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int HW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_ctrl;
  logic [2:0]    compare;
  logic          alusrc;
  logic [W-1:0]  rdata1, rdata2, imme;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [HW-1:0] result_high;
  logic          branch;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];   // {branch, result}

  alu_pipe #(.WIDTH(W), .HIGH_W(HW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_ctrl_i(alu_ctrl), .compare_i(compare), .alusrc_i(alusrc),
    .rdata1_i(rdata1), .rdata2_i(rdata2), .imme_i(imme),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .result_high_o(result_high), .branch_o(branch)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [2:0]   cmp;
    logic         src;
    logic [W-1:0] a;
    logic [W-1:0] r2;
    logic [W-1:0] imm;
    logic [W-1:0] exp_res;
    logic         exp_br;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: arithmetic formulation of the opcode / compare rules.
  function automatic logic [W:0] model(input logic [3:0] op, input logic [2:0] cmp,
                                       input logic src, input logic [W-1:0] a,
                                       input logic [W-1:0] r2, input logic [W-1:0] imm);
    logic [W-1:0] b, p, res, sa, sb;
    logic br;
    b   = src ? r2 : imm;
    p   = 32'd1 << (b % 32);
    sa  = a ^ 32'h8000_0000;   // bias so unsigned order equals signed order
    sb  = b ^ 32'h8000_0000;
    res = '0;
    case (op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = a + b;
      4'd6:  res = a + ~b + 32'd1;
      4'd3:  res = a ^ b;
      4'd4:  res = a * p;
      4'd5:  res = a / p;
      4'd7:  res = a[W-1] ? ~((~a) / p) : a / p;
      4'd8:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_PIPE_MUL_EN
      4'd10: res = a * b;
`endif
      default: res = '0;
    endcase
    case (cmp)
      3'd0:    br = (a == b);
      3'd1:    br = (a != b);
      3'd4:    br = (sa < sb);
      3'd5:    br = !(sa < sb);
      3'd6:    br = (a < b);
      3'd7:    br = !(a < b);
      default: br = 1'b0;
    endcase
    return {br, res};
  endfunction

  // One cycle: drive at negedge, observe, scoreboard output transfers and
  // record accepted ops; the transfers themselves happen at the next posedge.
  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] cmp,
                      input logic src, input logic [W-1:0] a, input logic [W-1:0] r2,
                      input logic [W-1:0] imm, input logic ordy,
                      output logic acc, output logic xfer);
    logic [W:0] e;
    @(negedge clk);
    in_valid = v; alu_ctrl = op; compare = cmp; alusrc = src;
    rdata1 = a; rdata2 = r2; imme = imm; out_ready = ordy;
    #1;
    acc  = in_valid & in_ready;
    xfer = out_valid & out_ready;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 64'(result), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 64'(result), 64'(e[W-1:0]));
        check("sb_branch", 64'(branch), 64'(e[W]));
      end
    end
    if (acc) exp_q.push_back(model(op, cmp, src, a, r2, imm));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc, xfer;
    logic [W-1:0] held;
    int sent, got, low_cnt;

    // reset
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; compare = '0; alusrc = 1'b0;
    rdata1 = '0; rdata2 = '0; imme = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_high", 64'(result_high), 64'd0);
    check("rst_branch", 64'(branch), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // directed vectors: op, cmp, src, a, r2, imm, expected result, expected branch
    vecs.push_back('{4'b0010, 3'b000, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h8000_0000, 1'b0});
    vecs.push_back('{4'b0111, 3'b010, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0024, 32'hF800_0000, 1'b0});
    vecs.push_back('{4'b0101, 3'b010, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0024, 32'h0800_0000, 1'b0});
    vecs.push_back('{4'b1001, 3'b100, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'b1000, 3'b110, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0000_0001, 1'b0});
    vecs.push_back('{4'b0110, 3'b001, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{4'b0011, 3'b000, 1'b0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'b0000, 3'b101, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000, 1'b0});
    vecs.push_back('{4'b0001, 3'b111, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{4'b0100, 3'b011, 1'b1, 32'h0000_0001, 32'h0000_0021, 32'h0, 32'h0000_0002, 1'b0});
    vecs.push_back('{4'b1111, 3'b100, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{4'b0010, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 1'b1});
`ifndef ALU_PIPE_MUL_EN
    vecs.push_back('{4'b1010, 3'b000, 1'b1, 32'h0001_0003, 32'h0000_0005, 32'h0, 32'h0000_0000, 1'b0});
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = vecs[i].op; compare = vecs[i].cmp; alusrc = vecs[i].src;
      rdata1 = vecs[i].a; rdata2 = vecs[i].r2; imme = vecs[i].imm; out_ready = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk); in_valid = 1'b0;
      #1 check($sformatf("vec%0d_lat1_valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_lat2_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d_high", i), 64'(result_high), 64'(vecs[i].exp_res[W-1:W-HW]));
      check($sformatf("vec%0d_branch", i), 64'(branch), 64'(vecs[i].exp_br));
    end
    @(negedge clk);

    // stall: four back-to-back ADDs with the consumer blocked for 5 cycles
    sent = 0; got = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      step(sent < 4, 4'b0010, 3'b000, 1'b1, 32'(100 * (sent + 1)), 32'(sent), 32'h0, 1'b0, acc, xfer);
      if (acc) sent++;
      if (c == 2) check("stall_in_ready_low", 64'(in_ready), 64'd0);
      if (c == 2) held = result;
      if (c > 2) check("stall_result_held", 64'(result), 64'(held));
    end
    check("stall_accepts", 64'(sent), 64'd2);
    for (int c = 0; c < 40 && got < 4; c++) begin
      step(sent < 4, 4'b0010, 3'b000, 1'b1, 32'(100 * (sent + 1)), 32'(sent), 32'h0, 1'b1, acc, xfer);
      if (acc) sent++;
      if (xfer) got++;
    end
    check("stall_all_results", 64'(got), 64'd4);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset with both stages full
    step(1'b1, 4'b0010, 3'b000, 1'b1, 32'h1, 32'h1, 32'h0, 1'b0, acc, xfer);
    step(1'b1, 4'b0010, 3'b000, 1'b1, 32'h2, 32'h2, 32'h0, 1'b0, acc, xfer);
    step(1'b0, 4'b0000, 3'b000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, acc, xfer);
    check("rstfull_pre_valid", 64'(out_valid), 64'd1);
    check("rstfull_pre_ready", 64'(in_ready), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rstfull_out_valid", 64'(out_valid), 64'd0);
    check("rstfull_result", 64'(result), 64'd0);
    check("rstfull_result_high", 64'(result_high), 64'd0);
    check("rstfull_branch", 64'(branch), 64'd0);
    check("rstfull_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    #1 check("rstfull_release_ready", 64'(in_ready), 64'd1);

`ifdef ALU_PIPE_MUL_EN
    // multiply: in_ready stays low while the multiplier iterates
    step(1'b1, 4'b1010, 3'b000, 1'b1, 32'h0001_0003, 32'h0000_0005, 32'h0, 1'b1, acc, xfer);
    check("mul_accept", 64'(acc), 64'd1);
    low_cnt = 0;
    for (int c = 0; c < W + 10 && exp_q.size() != 0; c++) begin
      step(1'b0, 4'b0000, 3'b000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, acc, xfer);
      if (!in_ready) low_cnt++;
    end
    check("mul_done", 64'(exp_q.size()), 64'd0);
    check("mul_ready_low_cycles", 64'(low_cnt >= W), 64'd1);
`else
    low_cnt = 0;
`endif

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), rand_operand(), rand_operand(), rand_operand(),
           $urandom_range(0, 9) < 6, acc, xfer);
    end
    for (int c = 0; c < 120 && exp_q.size() != 0; c++) begin
      step(1'b0, 4'b0000, 3'b000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, acc, xfer);
    end
    check("rand_drain_empty", 64'(exp_q.size()), 64'd0);
    step(1'b0, 4'b0000, 3'b000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, acc, xfer);
    check("rand_final_idle_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
